arb_word_packer: RTL
====================

Name: arb_word_packer

Overview:
- Downstream consumer of the round-robin FIFO arbiter's byte stream (dout/valid).
- Packs valid bytes into WORD_BYTES-wide words, little-endian.
- Buffers completed words in a small output queue with a valid/ready handshake toward the bus-side sink.
- The arbiter cannot be stalled, so the input side has no backpressure. Words that cannot be queued are dropped, flagged and counted.

Parameters:
- DW, 8, input byte width.
- WORD_BYTES, 4, bytes per output word; must be a power of 2, at least 2.
- QDEPTH, 2, output queue depth in words; at least 1.
- CW, 8, drop counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  byte present on in_data this cycle (arbiter valid).
- in_data  input  DW  byte (arbiter dout).
- flush  input  1  single-cycle request to emit the current partial word.
- out_ready  input  1  sink accepts the head word this cycle.
- out_valid  output  1  queue non-empty.
- out_data  output  DW*WORD_BYTES  head word; byte k in bits [DW*k+DW-1 : DW*k].
- out_bytes  output  clog2(WORD_BYTES)+1  number of valid bytes in the head word (1..WORD_BYTES).
- overflow  output  1  one-cycle pulse: a word was dropped.
- drop_count  output  CW  saturating count of dropped words.

Behaviour:
- Reset (rst_n=0 at posedge): byte index idx=0, assembly register=0, queue empty, out_valid=0, out_data=0, out_bytes=0, overflow=0, drop_count=0.
- Reset mid-operation discards the partial word and all queued words, and issues no overflow pulse.
- Assembly, with in_valid=1:
  - in_data is written to lane idx.
  - If idx<WORD_BYTES-1: idx increments.
  - If idx=WORD_BYTES-1: the word completes. The full word (including this byte) is enqueued with bytes=WORD_BYTES, idx<=0 and the assembly register is cleared.
- Unused lanes of any enqueued word are 0.
- Flush:
  - Evaluated after the same-cycle byte is applied.
  - If the resulting fill count n>0 and the word did not just complete, the partial word is enqueued with bytes=n, then idx<=0 and the register is cleared.
  - flush with n=0, or on a completing cycle, is a no-op.
- Enqueue rule: accepted if queue count<QDEPTH, or if a pop happens the same cycle. Simultaneous push and pop when full is legal and count is unchanged.
- Drop path: on rejected enqueue:
  - The word is discarded and assembly still restarts at idx=0.
  - overflow=1 on the next cycle only.
  - drop_count increments and saturates at 2^CW-1.
- Dequeue:
  - out_valid = count>0.
  - out_data/out_bytes are read from the head entry (register storage, combinational head select).
  - Pop when out_valid & out_ready; out_ready while empty is ignored.
- Latency: the completing byte (or flush) at posedge N gives out_valid=1 after posedge N, visible in cycle N+1, when the queue was empty.
- Queue order is strict FIFO; queue pointers wrap modulo QDEPTH.
- in_valid=0 cycles leave idx and the assembly register untouched. There is no timeout; partial words wait indefinitely for more bytes or flush.

Decomposition:
- Shared package: DW, WORD_BYTES, the derived index width clog2(WORD_BYTES), and the bytes-field width.
- One sub-module, word_queue: parameterised register FIFO carrying {bytes, data}.
  - Ports: push, push_data, pop, head, count/full/empty.
  - Push accepted when not full or when popping.
- Packing FSM, flush logic and drop counter live in the top module.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 → next cycle out_valid=1, out_data=0x44332211, out_bytes=4; the queue then drains.
- Bytes 0xAA,0xBB, then flush with in_valid=0 → out_data=0x0000BBAA, out_bytes=2. A flush with in_valid=1 and byte 0xCC after 0xAA gives 0x0000CCAA, out_bytes=2.
- out_ready=0, 12 bytes 0x01..0x0C:
  - Words 0x04030201 and 0x08070605 are queued.
  - The third word is dropped: overflow pulses one cycle, drop_count=1.
  - Then raise out_ready: exactly the two queued words appear, in order.
- Queue full with out_ready=1 on the same cycle a new word completes → no drop, count stays 2, drop_count unchanged.
- Drops with out_ready=0 held: at CW=8, drop_count stops at 255 after ≥255 drops.
- Reset asserted after 2 bytes with 1 word queued → out_valid=0, drop_count=0. The next 4 bytes 0x01..0x04 give 0x04030201, so no stale lanes remain.

Source files
------------

// File: rtl/arb_word_packer_pkg.sv
// Shared defaults and width helpers for the arbiter word packer.
package arb_word_packer_pkg;

    localparam int unsigned DEF_DW         = 8;
    localparam int unsigned DEF_WORD_BYTES = 4;
    localparam int unsigned DEF_QDEPTH     = 2;
    localparam int unsigned DEF_CW         = 8;

    function automatic int unsigned idx_w(input int unsigned wb);
        return $clog2(wb);
    endfunction

    function automatic int unsigned bytes_w(input int unsigned wb);
        return $clog2(wb) + 1;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_word_packer_word_queue.sv
// Register-based FIFO for packed words; push is accepted when not full or when popping.
module arb_word_packer_word_queue
    import arb_word_packer_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PW   = ptr_w(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   rd_q, wr_q;
    logic [CNTW-1:0] cnt_q;
    logic            push_en, pop_en;

    // Pointers wrap explicitly so non-power-of-2 depths stay correct.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full_o  = (cnt_q == CNTW'(DEPTH));
        empty_o = (cnt_q == '0);
        count_o = cnt_q;
        head_o  = mem_q[rd_q];
        pop_en  = pop_i && !empty_o;
        push_en = push_i && (!full_o || pop_en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (pop_en) begin
                rd_q <= next_ptr(rd_q);
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/arb_word_packer.sv
// Packs the arbiter byte stream into little-endian words, queues them, drops and counts on overflow.
module arb_word_packer
    import arb_word_packer_pkg::*;
#(
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
    parameter int unsigned QDEPTH     = DEF_QDEPTH,
    parameter int unsigned CW         = DEF_CW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DW-1:0]                    in_data,
    input  logic                             flush,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [DW*WORD_BYTES-1:0]         out_data,
    output logic [bytes_w(WORD_BYTES)-1:0]   out_bytes,
    output logic                             overflow,
    output logic [CW-1:0]                    drop_count
);

    localparam int unsigned IW = idx_w(WORD_BYTES);
    localparam int unsigned BW = bytes_w(WORD_BYTES);
    localparam int unsigned WW = DW * WORD_BYTES;
    localparam int unsigned EW = BW + WW;

    logic [IW-1:0]                    idx_q, idx_d;
    logic [WORD_BYTES-1:0][DW-1:0]    asm_q, asm_d, asm_w;
    logic [BW-1:0]                    fill, push_bytes;
    logic                             complete, do_flush, push, pop, accept, drop;
    logic                             ovf_q;
    logic [CW-1:0]                    drop_q;
    logic                             q_full, q_empty;
    logic [$clog2(QDEPTH+1)-1:0]      q_count;
    logic [EW-1:0]                    q_head;

    always_comb begin
        asm_w = asm_q;
        if (in_valid) begin
            asm_w[idx_q] = in_data;
        end
        // Fill count after this cycle's byte; flush sees it, a completing byte wins over flush.
        fill       = {1'b0, idx_q} + BW'(in_valid);
        complete   = in_valid && (idx_q == IW'(WORD_BYTES - 1));
        do_flush   = flush && !complete && (fill != '0);
        push       = complete || do_flush;
        push_bytes = complete ? BW'(WORD_BYTES) : fill;
        pop        = out_ready && !q_empty;
        accept     = push && (!q_full || pop);
        drop       = push && !accept;

        idx_d = idx_q;
        asm_d = asm_q;
        if (push) begin
            idx_d = '0;
            asm_d = '0;
        end else if (in_valid) begin
            idx_d = idx_q + 1'b1;
            asm_d = asm_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            asm_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
            ovf_q <= drop;
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    arb_word_packer_word_queue #(
        .W     (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({push_bytes, asm_w}),
        .pop_i       (pop),
        .head_o      (q_head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    always_comb begin
        out_valid  = (q_count != '0);
        out_bytes  = q_head[EW-1 -: BW];
        out_data   = q_head[WW-1:0];
        overflow   = ovf_q;
        drop_count = drop_q;
    end

endmodule
